tia_line_timing_generator: RTL and testbench
============================================

# tia_line_timing_generator

Parametrised horizontal/line timing generator for the TIA core. It generalises the fixed 228-clock horizontal timing path to a configurable line length, blank window, sync window and HMOVE blank extension. It adds a programmable HMOVE motion-pulse train and WSYNC/RSYNC handling. It sits between the write address decodes and the object/colour logic, driving blank, sync, CPU ready and line-start.

## Interface
- LINE_CLOCKS, 228, colour clocks per line.
- HBLANK_CLOCKS, 68, clocks of horizontal blank at line start.
- HSYNC_START, 16, first clock of horizontal sync.
- HSYNC_WIDTH, 16, sync width in clocks.
- HMOVE_EXTEND, 8, extra blank clocks on an HMOVE line.
- MOTION_PULSES, 15, motion pulses emitted per HMOVE.
- MOTION_SPACING, 4, clocks between motion pulses.
- COUNTER_WIDTH, 8, width of hcount; 2^COUNTER_WIDTH ≥ LINE_CLOCKS.
- clk  in  1  colour clock (osc).
- reset_bar  in  1  asynchronous, active-low reset.
- wsyn  in  1  WSYNC strobe, one clk wide.
- rsyn  in  1  RSYNC strobe, one clk wide.
- hmove  in  1  HMOVE strobe, one clk wide.
- vsyn  in  1  VSYNC register write strobe.
- vblk  in  1  VBLANK register write strobe.
- d1  in  1  latched data bit 1.
- hcount  out  COUNTER_WIDTH  horizontal position.
- line_start  out  1  high while hcount == 0.
- blank  out  1  composite blank.
- syn  out  1  composite sync.
- rdy  out  1  CPU ready; low while WSYNC is pending.
- motck  out  1  motion clock pulse, one clk wide.

## Operation
- hcount increments every clk. It wraps LINE_CLOCKS-1 → 0.
- rsyn forces hcount to 0 on the next edge. This overrides increment and wrap.
- "Line boundary" means the edge where hcount becomes 0, by either wrap or rsyn.
- vsyn_l and vblk_l load d1 on the edge after their write strobe. Otherwise they hold.
- hsync = (HSYNC_START ≤ hcount < HSYNC_START+HSYNC_WIDTH).
- syn = hsync XOR vsyn_l. A VSYNC line therefore carries inverted serration pulses.
- HMOVE flags:
  - hmove with hcount < HBLANK_CLOCKS sets hm_cur.
  - hmove at any other hcount sets hm_next.
  - At a line boundary: hm_cur ← hm_next | (hmove this cycle); hm_next ← 0.
- hblank = hcount < HBLANK_CLOCKS, or hm_cur and hcount < HBLANK_CLOCKS+HMOVE_EXTEND.
- blank = hblank | vblk_l.
- Motion pulse train:
  - Any hmove loads pulses_left ← MOTION_PULSES and spacing ← 0. This retriggers a train already in progress.
  - While pulses_left ≠ 0: motck = 1 when spacing == 0; spacing counts 0..MOTION_SPACING-1 and wraps; pulses_left decrements on each emitted pulse.
  - motck is registered. The first pulse appears on the edge after hmove.
- WSYNC: wsyn clears rdy on the next edge. rdy returns to 1 on the next line boundary.
  - If wsyn coincides with a line boundary, the release wins and rdy stays 1.
- Elaboration-time requirements (violation is a fatal error):
  - HSYNC_START+HSYNC_WIDTH ≤ HBLANK_CLOCKS.
  - HBLANK_CLOCKS+HMOVE_EXTEND < LINE_CLOCKS.
  - MOTION_PULSES·MOTION_SPACING < LINE_CLOCKS.
  - MOTION_SPACING ≥ 1.

## Timing
- All state changes on rising clk: hcount, vsyn_l, vblk_l, hm_cur, hm_next, rdy, pulses_left, spacing, motck.
- Decoded outputs are combinational from that state and change on the same edge as hcount: line_start, blank, syn.
- Reset (reset_bar low, asynchronous), held until release:
  - hcount = 0, line_start = 1.
  - blank = 1, syn = 0.
  - rdy = 1, motck = 0.
  - All flags and counters 0.
- First increment occurs on the first clk edge after reset_bar rises.
- Latency from a strobe to its effect is 1 clk: wsyn→rdy, rsyn→hcount, hmove→motck, vsyn/vblk→syn/blank.
- Simultaneous rsyn and wrap: result is hcount = 0, one line boundary.
- Simultaneous hmove and line boundary: the new line is extended.
- reset_bar asserted mid-line or mid-train: everything returns to reset values immediately. No partial pulse is emitted.

## Test plan
- Free-run with defaults after reset. Required: hcount 0..227 then 0; line_start period 228; blank high for hcount 0–67; syn high for hcount 16–31.
- hmove at hcount 3. Required: blank high for hcount 0–75 on that line; motck pulses at hcount 4, 8, …, 60 (15 pulses); next line blank is 0–67 again.
- hmove at hcount 100. Required: the current line is unaffected; the next line blanks 0–75; a second hmove at hcount 104 restarts the train (15 pulses starting at hcount 105).
- wsyn at hcount 50. Required: rdy = 0 from hcount 51 through 227, and 1 when hcount = 0. wsyn at hcount 227: rdy stays 1.
- rsyn at hcount 120. Required: hcount = 0 next clk; line_start pulses; pending rdy released. vsyn with d1 = 1: syn inverted (low during hcount 16–31, high elsewhere).
- Parameters LINE_CLOCKS = 160, HBLANK_CLOCKS = 40, HSYNC_START = 8, HSYNC_WIDTH = 8. Assert reset_bar mid-line at hcount 90, hold, release. Required: 160-clock period, blank for hcount 0–39, immediate reset values, restart from hcount 0.

Source files
------------

// File: rtl/tia_line_timing_generator.sv
// TIA horizontal line timing: position counter, blank/sync decode, HMOVE
// blank extension and motion pulse train, WSYNC/RSYNC CPU ready handling.
module tia_line_timing_generator #(
  parameter int LINE_CLOCKS    = 228,
  parameter int HBLANK_CLOCKS  = 68,
  parameter int HSYNC_START    = 16,
  parameter int HSYNC_WIDTH    = 16,
  parameter int HMOVE_EXTEND   = 8,
  parameter int MOTION_PULSES  = 15,
  parameter int MOTION_SPACING = 4,
  parameter int COUNTER_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_bar,
  input  logic                     wsyn,
  input  logic                     rsyn,
  input  logic                     hmove,
  input  logic                     vsyn,
  input  logic                     vblk,
  input  logic                     d1,
  output logic [COUNTER_WIDTH-1:0] hcount,
  output logic                     line_start,
  output logic                     blank,
  output logic                     syn,
  output logic                     rdy,
  output logic                     motck
);

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;

  localparam int PW = (MOTION_PULSES < 1) ? 1 : $clog2(MOTION_PULSES + 1);
  localparam int SW = (MOTION_SPACING > 1) ? $clog2(MOTION_SPACING) : 1;

  localparam cnt_t LAST   = cnt_t'(LINE_CLOCKS - 1);
  localparam cnt_t HB     = cnt_t'(HBLANK_CLOCKS);
  localparam cnt_t HB_EXT = cnt_t'(HBLANK_CLOCKS + HMOVE_EXTEND);
  localparam cnt_t HS_LO  = cnt_t'(HSYNC_START);
  localparam cnt_t HS_HI  = cnt_t'(HSYNC_START + HSYNC_WIDTH);

  localparam logic [PW-1:0] NP    = PW'(MOTION_PULSES);
  localparam logic [SW-1:0] SLAST = SW'(MOTION_SPACING - 1);
  localparam logic [SW-1:0] SFST  = (MOTION_SPACING > 1) ? SW'(1) : SW'(0);

  if (HSYNC_START + HSYNC_WIDTH > HBLANK_CLOCKS) begin : g_chk_sync
    $fatal(1, "HSYNC window must end inside horizontal blank");
  end
  if (HBLANK_CLOCKS + HMOVE_EXTEND >= LINE_CLOCKS) begin : g_chk_ext
    $fatal(1, "extended blank must be shorter than the line");
  end
  if (MOTION_PULSES * MOTION_SPACING >= LINE_CLOCKS) begin : g_chk_train
    $fatal(1, "motion train must fit inside one line");
  end
  if (MOTION_SPACING < 1) begin : g_chk_spc
    $fatal(1, "MOTION_SPACING must be at least 1");
  end
  if ((2 ** COUNTER_WIDTH) < LINE_CLOCKS) begin : g_chk_cw
    $fatal(1, "COUNTER_WIDTH too narrow for LINE_CLOCKS");
  end

  cnt_t          hcount_q, hcount_d;
  logic          vsyn_l_q, vsyn_l_d, vblk_l_q, vblk_l_d;
  logic          hm_cur_q, hm_cur_d, hm_next_q, hm_next_d;
  logic          rdy_q, rdy_d, motck_q, motck_d;
  logic [PW-1:0] pulses_q, pulses_d;
  logic [SW-1:0] spacing_q, spacing_d;
  logic          boundary;

  always_comb begin
    boundary  = rsyn | (hcount_q == LAST);
    hcount_d  = boundary ? '0 : hcount_q + cnt_t'(1);
    vsyn_l_d  = vsyn ? d1 : vsyn_l_q;
    vblk_l_d  = vblk ? d1 : vblk_l_q;
    rdy_d     = boundary ? 1'b1 : (wsyn ? 1'b0 : rdy_q);
    hm_cur_d  = hm_cur_q;
    hm_next_d = hm_next_q;
    // An HMOVE landing on the boundary cycle extends the line being started.
    if (boundary) begin
      hm_cur_d  = hm_next_q | hmove;
      hm_next_d = 1'b0;
    end else if (hmove) begin
      if (hcount_q < HB) hm_cur_d  = 1'b1;
      else               hm_next_d = 1'b1;
    end
    pulses_d  = pulses_q;
    spacing_d = spacing_q;
    motck_d   = 1'b0;
    // The hmove edge itself emits pulse one, so the train resumes at slot 1.
    if (hmove) begin
      motck_d   = 1'b1;
      pulses_d  = NP - PW'(1);
      spacing_d = SFST;
    end else if (pulses_q != '0) begin
      motck_d   = (spacing_q == '0);
      if (spacing_q == '0) pulses_d = pulses_q - PW'(1);
      spacing_d = (spacing_q == SLAST) ? '0 : spacing_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      hcount_q  <= '0;
      vsyn_l_q  <= 1'b0;
      vblk_l_q  <= 1'b0;
      hm_cur_q  <= 1'b0;
      hm_next_q <= 1'b0;
      rdy_q     <= 1'b1;
      motck_q   <= 1'b0;
      pulses_q  <= '0;
      spacing_q <= '0;
    end else begin
      hcount_q  <= hcount_d;
      vsyn_l_q  <= vsyn_l_d;
      vblk_l_q  <= vblk_l_d;
      hm_cur_q  <= hm_cur_d;
      hm_next_q <= hm_next_d;
      rdy_q     <= rdy_d;
      motck_q   <= motck_d;
      pulses_q  <= pulses_d;
      spacing_q <= spacing_d;
    end
  end

  assign hcount     = hcount_q;
  assign line_start = (hcount_q == '0);
  assign blank      = (hcount_q < HB) | (hm_cur_q & (hcount_q < HB_EXT)) | vblk_l_q;
  assign syn        = ((hcount_q >= HS_LO) && (hcount_q < HS_HI)) ^ vsyn_l_q;
  assign rdy        = rdy_q;
  assign motck      = motck_q;

endmodule

// File: tb/tb_tia_line_timing_generator.sv
// Bench for tia_line_timing_generator: a default instance and a short-line
// instance, both compared every clock against a line-level reference model.
module tb_tia_line_timing_generator;
  localparam int NI = 2;

  int LC [NI] = '{228, 160};
  int HB [NI] = '{68, 40};
  int HS [NI] = '{16, 8};
  int HW [NI] = '{16, 8};
  int EXT[NI] = '{8, 8};
  int NP [NI] = '{15, 15};
  int SP [NI] = '{4, 4};

  logic       clk;
  logic       rst_n[NI], wsyn[NI], rsyn[NI], hmove[NI], vsyn[NI], vblk[NI], d1[NI];
  logic [7:0] hc_o[NI];
  logic       ls_o[NI], blank_o[NI], syn_o[NI], rdy_o[NI], motck_o[NI];

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int m_hc[NI], m_edge[NI], m_hme[NI];
  bit m_rdy[NI], m_cur[NI], m_nxt[NI], m_vs[NI], m_vb[NI], m_has[NI];

  tia_line_timing_generator u_dut0 (
    .clk(clk), .reset_bar(rst_n[0]), .wsyn(wsyn[0]), .rsyn(rsyn[0]), .hmove(hmove[0]),
    .vsyn(vsyn[0]), .vblk(vblk[0]), .d1(d1[0]), .hcount(hc_o[0]), .line_start(ls_o[0]),
    .blank(blank_o[0]), .syn(syn_o[0]), .rdy(rdy_o[0]), .motck(motck_o[0])
  );

  tia_line_timing_generator #(
    .LINE_CLOCKS(160), .HBLANK_CLOCKS(40), .HSYNC_START(8), .HSYNC_WIDTH(8)
  ) u_dut1 (
    .clk(clk), .reset_bar(rst_n[1]), .wsyn(wsyn[1]), .rsyn(rsyn[1]), .hmove(hmove[1]),
    .vsyn(vsyn[1]), .vblk(vblk[1]), .d1(d1[1]), .hcount(hc_o[1]), .line_start(ls_o[1]),
    .blank(blank_o[1]), .syn(syn_o[1]), .rdy(rdy_o[1]), .motck(motck_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_hc[i] = 0; m_edge[i] = 0; m_hme[i] = 0;
    m_rdy[i] = 1; m_cur[i] = 0; m_nxt[i] = 0; m_vs[i] = 0; m_vb[i] = 0; m_has[i] = 0;
  endtask

  task automatic model_edge(input int i);
    bit bnd;
    bnd = rsyn[i] || (m_hc[i] == LC[i] - 1);
    m_edge[i]++;
    if (hmove[i]) begin m_has[i] = 1; m_hme[i] = m_edge[i]; end
    if (bnd) begin
      m_cur[i] = m_nxt[i] | hmove[i];
      m_nxt[i] = 0;
    end else if (hmove[i]) begin
      if (m_hc[i] < HB[i]) m_cur[i] = 1;
      else                 m_nxt[i] = 1;
    end
    m_rdy[i] = bnd ? 1'b1 : (wsyn[i] ? 1'b0 : m_rdy[i]);
    if (vsyn[i]) m_vs[i] = d1[i];
    if (vblk[i]) m_vb[i] = d1[i];
    m_hc[i] = bnd ? 0 : m_hc[i] + 1;
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int d;
      bit mexp, bexp, sexp;
      d    = m_edge[i] - m_hme[i];
      mexp = m_has[i] && (d % SP[i] == 0) && (d / SP[i] < NP[i]);
      bexp = (m_hc[i] < HB[i]) || (m_cur[i] && m_hc[i] < HB[i] + EXT[i]) || m_vb[i];
      sexp = ((m_hc[i] >= HS[i]) && (m_hc[i] < HS[i] + HW[i])) ^ m_vs[i];
      check($sformatf("u%0d.hcount", i), 32'(hc_o[i]), 32'(m_hc[i]));
      check($sformatf("u%0d.line_start", i), 32'(ls_o[i]), 32'(m_hc[i] == 0));
      check($sformatf("u%0d.blank", i), 32'(blank_o[i]), 32'(bexp));
      check($sformatf("u%0d.syn", i), 32'(syn_o[i]), 32'(sexp));
      check($sformatf("u%0d.rdy", i), 32'(rdy_o[i]), 32'(m_rdy[i]));
      check($sformatf("u%0d.motck@hc%0d", i, m_hc[i]), 32'(motck_o[i]), 32'(mexp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < NI; i++) if (rst_n[i]) model_edge(i);
    #1;
    for (int i = 0; i < NI; i++) begin
      wsyn[i] = 0; rsyn[i] = 0; hmove[i] = 0; vsyn[i] = 0; vblk[i] = 0;
    end
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic go_to(input int i, input int target);
    for (int k = 0; k < 600 && m_hc[i] != target; k++) step();
    check($sformatf("u%0d.reach_hc%0d", i, target), 32'(m_hc[i]), 32'(target));
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 0; wsyn[i] = 0; rsyn[i] = 0; hmove[i] = 0;
      vsyn[i] = 0; vblk[i] = 0; d1[i] = 0;
      model_reset(i);
    end
    repeat (3) @(posedge clk);
    #1;
    check_all();
    check("rst.hcount", 32'(hc_o[0]), 0);
    check("rst.blank", 32'(blank_o[0]), 1);
    check("rst.syn", 32'(syn_o[0]), 0);
    check("rst.rdy", 32'(rdy_o[0]), 1);
    rst_n[0] = 1; rst_n[1] = 1;
    step();
    check("first_incr", 32'(hc_o[0]), 1);

    // Free run across several lines on both instances
    run(470);

    // HMOVE early in the line: extends this line, 15-pulse train
    go_to(0, 3); hmove[0] = 1; step();
    run(300);

    // HMOVE late in the line extends the next; second HMOVE retriggers
    go_to(0, 100); hmove[0] = 1; step();
    go_to(0, 104); hmove[0] = 1; step();
    run(400);

    // WSYNC mid-line, then WSYNC on the wrap cycle
    go_to(0, 50); wsyn[0] = 1; step();
    check("wsyn50.rdy", 32'(rdy_o[0]), 0);
    go_to(0, 227); wsyn[0] = 1; step();
    check("wsyn227.rdy", 32'(rdy_o[0]), 1);

    // RSYNC releases a pending WSYNC
    go_to(0, 60); wsyn[0] = 1; step();
    go_to(0, 120); rsyn[0] = 1; step();
    check("rsyn.hcount", 32'(hc_o[0]), 0);
    check("rsyn.rdy", 32'(rdy_o[0]), 1);

    // VSYNC with d1=1 inverts sync; VBLANK forces blank
    vsyn[0] = 1; d1[0] = 1; step();
    run(240);
    vsyn[0] = 1; d1[0] = 0; step();
    vblk[0] = 1; d1[0] = 1; step();
    run(120);
    vblk[0] = 1; d1[0] = 0; step();

    // Short-line instance: reset asynchronously mid-line during a train
    go_to(1, 80); hmove[1] = 1; step();
    go_to(1, 90);
    #2 rst_n[1] = 0;
    #1 model_reset(1);
    check_all();
    check("u1.async_rst.hcount", 32'(hc_o[1]), 0);
    check("u1.async_rst.motck", 32'(motck_o[1]), 0);
    run(3);
    rst_n[1] = 1;
    run(400);

    // Random strobes on both instances
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < NI; i++) begin
        hmove[i] = ($urandom_range(0, 63) == 0);
        wsyn[i]  = ($urandom_range(0, 63) == 0);
        rsyn[i]  = ($urandom_range(0, 199) == 0);
        vsyn[i]  = ($urandom_range(0, 99) == 0);
        vblk[i]  = ($urandom_range(0, 99) == 0);
        d1[i]    = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
